// File: rtl/spi_peripheral.sv
// SPI peripheral (mode 0, 16-bit frames) holding the five PWM control registers.
// Frame layout, MSB first: [15] R/W (1 = write), [14:8] address, [7:0] data.
// Optional feature macro: SPI_READBACK_EN. When it is defined, read frames
// (bit15 == 0) return the addressed register on spi_cipo. When it is not
// defined, spi_cipo is tied low and read frames are discarded.
// Handshake note: there is no valid/ready pair here. A frame is the span
// between a synchronized nCS fall and rise. It is accepted only when exactly
// 16 SCLK rising edges occurred inside that span.
module spi_peripheral (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_copi,
  input  logic       spi_ncs,
  output logic       spi_cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVF  = 5'd17;

  state_t      state;
  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0]  sclk_sync;
  logic [2:0]  ncs_sync;
  logic [1:0]  copi_sync;
  // Fills with ones after reset, so the bench-visible nCS level is a real pin sample
  logic [1:0]  sync_ok;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;

  logic ncs_s;
  logic ncs_rise;
  logic ncs_fall;
  logic sclk_rise;
  logic copi_s;
  logic frame_ok;

  assign ncs_s     = ncs_sync[1];
  assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
  assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign copi_s    = copi_sync[1];
  assign fsm_state = state;

  // A write is accepted only for exactly 16 bits, the W flag set, and a mapped address
  assign frame_ok = (bit_cnt == CNT_FULL) && shreg[15] && (shreg[14:8] <= 7'h04);

  // Bring the SPI pins into the clk domain; reset values model an idle bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 3'b000;
      ncs_sync  <= 3'b111;
      copi_sync <= 2'b00;
      sync_ok   <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      ncs_sync  <= {ncs_sync[1:0], spi_ncs};
      copi_sync <= {copi_sync[0], spi_copi};
      sync_ok   <= {sync_ok[0], 1'b1};
    end
  end

  // Frame FSM, shifter and register file. The write is issued on the edge that
  // enters COMMIT, so a register lands on the 3rd clk edge after nCS rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= WAIT_IDLE;
      bit_cnt         <= 5'd0;
      shreg           <= 16'h0000;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      case (state)
        WAIT_IDLE: begin
          // Stay here until the bus is seen idle, so a frame cut by reset is never picked up
          if (sync_ok[1] && ncs_s) state <= IDLE;
        end
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            bit_cnt <= 5'd0;
            shreg   <= 16'h0000;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
            if (frame_ok) begin
              case (shreg[10:8])
                3'd0:    en_reg_out_7_0  <= shreg[7:0];
                3'd1:    en_reg_out_15_8 <= shreg[7:0];
                3'd2:    en_reg_pwm_7_0  <= shreg[7:0];
                3'd3:    en_reg_pwm_15_8 <= shreg[7:0];
                3'd4:    pwm_duty_cycle  <= shreg[7:0];
                default: ;
              endcase
            end
          end else if (sclk_rise) begin
            shreg <= {shreg[14:0], copi_s};
            // Saturating at 17 marks any over-long frame as invalid
            if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_byte;
  logic       rd_active;

  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  // The 8th bit is still on copi_s when the command byte completes
  assign rd_addr   = {shreg[5:0], copi_s};

  // Register read mux; addresses beyond the map read as zero
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      7'h00:   rd_data = en_reg_out_7_0;
      7'h01:   rd_data = en_reg_out_15_8;
      7'h02:   rd_data = en_reg_pwm_7_0;
      7'h03:   rd_data = en_reg_pwm_15_8;
      7'h04:   rd_data = pwm_duty_cycle;
      default: rd_data = 8'h00;
    endcase
  end

  // Load the read byte after bit 8 and present it MSB first on SCLK falling edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte   <= 8'h00;
      rd_active <= 1'b0;
      spi_cipo  <= 1'b0;
    end else if (ncs_s || state != SHIFT) begin
      rd_active <= 1'b0;
      spi_cipo  <= 1'b0;
    end else if (sclk_rise && bit_cnt == 5'd7 && !shreg[6]) begin
      rd_active <= 1'b1;
      tx_byte   <= rd_data;
    end else if (sclk_fall && rd_active) begin
      spi_cipo <= tx_byte[7];
      tx_byte  <= {tx_byte[6:0], 1'b0};
    end
  end
`else
  assign spi_cipo = 1'b0;
`endif

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL provide a single clock and an asynchronous active-high reset: clk input 1 (system clock, all state on rising edge); rst input 1 (async active-high reset).
REQ-002 SHALL have input spi_sclk, 1 bit: SPI serial clock from the controller, asynchronous to clk.
REQ-003 SHALL have input spi_copi, 1 bit: controller-out/peripheral-in serial data.
REQ-004 SHALL have input spi_ncs, 1 bit: active-low chip select that frames each transaction.
REQ-005 SHALL have output spi_cipo, 1 bit: peripheral-out serial data, used only with SPI_READBACK_EN.
REQ-006 SHALL have outputs en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each 8 bits: register file contents that feed the PWM peripheral.

Function
REQ-007 SHALL pass spi_sclk, spi_copi and spi_ncs each through a 2-flop synchronizer to clk, then detect edges by comparing against a third flop.
REQ-008 SHALL use SPI mode 0: sample COPI on synchronized SCLK rising edge, MSB first; supported SCLK is at most clk/8.
REQ-009 SHALL use a 16-bit frame: bit15 R/W (1=write), bits14:8 address, bits7:0 data.
REQ-010 SHALL map register addresses as 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
REQ-011 SHALL implement an FSM with states WAIT_IDLE (synced nCS low; ignore bus), IDLE, SHIFT and COMMIT.
REQ-012 SHALL transition WAIT_IDLE->IDLE when synced nCS is high.
REQ-013 SHALL transition IDLE->SHIFT on synced nCS falling edge, clearing the bit counter and shift register.
REQ-014 SHALL, in SHIFT, shift one bit per SCLK rising edge; the 5-bit counter saturates at 17 (overflow marker).
REQ-015 SHALL transition SHIFT->COMMIT on synced nCS rising edge, and COMMIT->IDLE unconditionally after 1 cycle.
REQ-016 SHALL, in COMMIT, update the addressed register only if count==16, bit15==1 and address<=0x04; otherwise discard the frame with no register change.
REQ-017 SHALL complete a register update at the 3rd clk rising edge after spi_ncs rises at the pin, given setup time is met.
REQ-018 SHALL ignore SCLK edges while synced nCS is high or the FSM is in WAIT_IDLE.
REQ-019 SHALL hold register outputs stable between commits; only one register changes per frame.

Reset
REQ-020 SHALL, while rst is high, force all five register outputs to 0x00, spi_cipo to 0, the counter and shift register to 0, and the FSM to WAIT_IDLE.
REQ-021 SHALL reset synchronizer flops to nCS=1, SCLK=0 and COPI=0.
REQ-022 SHALL abort any frame in progress when reset is asserted mid-frame; the remainder of that frame SHALL cause no update, and nCS must return high before a new frame is accepted.

Configuration
REQ-023 SHALL, when SPI_READBACK_EN is defined, treat bit15==0 as a read.
REQ-024 SHALL, for a read with SPI_READBACK_EN defined, load the addressed register after the 8th bit and drive it MSB first on spi_cipo, updated on synced SCLK falling edges during bits 8-15.
REQ-025 SHALL, for a read with SPI_READBACK_EN defined, return 0x00 for addresses above 0x04, drive spi_cipo to 0 while nCS is high, and make no register change.
REQ-026 SHALL, when SPI_READBACK_EN is undefined, tie spi_cipo to 0 and discard read frames.

Verification
REQ-027 SHALL cover: frame 0x80F0 -> en_reg_out_7_0=0xF0 within 3 clk after nCS rise; other registers remain 0x00.
REQ-028 SHALL cover: frame 0x8455 -> pwm_duty_cycle=0x55; a following frame 0x8555 (address 0x05) -> no register changes.
REQ-029 SHALL cover: a 12-bit frame 0x80F (nCS rises early) and a 17-bit frame -> all registers unchanged.
REQ-030 SHALL cover: rst pulsed at bit 6 of frame 0x81AA with nCS held low, then the remaining bits and nCS rise -> all registers 0x00; a next frame 0x81AA -> en_reg_out_15_8=0xAA.
REQ-031 SHALL cover: 20 SCLK pulses with nCS high -> no change; with SPI_READBACK_EN and pwm_duty_cycle=0x80, read frame 0x0400 -> spi_cipo bits 10000000.
REQ-032 SHALL cover: without SPI_READBACK_EN, frame 0x0000 -> spi_cipo=0 throughout and registers unchanged.
